fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `sync_fifo` write port among NREQ producers, e.g. shader cores pushing result lines toward the IO path. Each producer offers WIDTH-byte beats on a valid/ready handshake. The arbiter locks a grant for a burst of up to MAX_BURST beats, then rotates priority. Data muxing is combinational so the FIFO's `full` flag gates every write in the same cycle and no beat is ever dropped.

## Interface
- `WIDTH`, default 256: beat size in bytes; data buses are 8*WIDTH bits.
- `NREQ`, default 4: number of requesters, minimum 2.
- `MAX_BURST`, default 4: maximum beats per grant, minimum 1.
- `IW` (localparam) = max(1, clog2(NREQ)). `BW` (localparam) = clog2(MAX_BURST+1).

Ports:
- `CLK`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  per-requester beat valid.
- `req_last`  in  NREQ  per-requester marker: the current beat ends the burst.
- `req_data`  in  NREQ*8*WIDTH  requester i occupies bits [i*8*WIDTH +: 8*WIDTH].
- `req_ready`  out  NREQ  one-hot beat-accept strobe.
- `fifo_full`  in  1  connected to `sync_fifo.full`.
- `fifo_wr_en`  out  1  connected to `sync_fifo.wr_en`.
- `fifo_data`  out  8*WIDTH  connected to `sync_fifo.data_in`.
- `grant_id`  out  IW  index of the current or last grant holder.
- `busy`  out  1  high while a grant is locked.

## Operation
- State machine with two states: IDLE and LOCK.
- **IDLE:**
  - If any `req_valid` bit is high, select the first valid index scanning upward from `rr_ptr`, wrapping modulo NREQ.
  - Register that index into `grant_id`, clear `beat_cnt`, and go to LOCK.
  - If no request is valid, stay in IDLE.
  - No transfers occur in IDLE.
- **LOCK (grant g):**
  - A beat is accepted when `req_valid[g] && !fifo_full`.
  - On an accepted beat: `fifo_wr_en`=1, `req_ready[g]`=1, `fifo_data` = slice g of `req_data`, and `beat_cnt` increments.
  - The burst ends on an accepted beat when `req_last[g]`=1 or `beat_cnt+1 == MAX_BURST`.
  - At burst end: go to IDLE, set `rr_ptr` to (g+1) mod NREQ, and hold `grant_id`.
- **Stalls:**
  - If `req_valid[g]` drops mid-burst, the grant is held with no timeout. A requester must complete its burst.
  - If `fifo_full` is high, `fifo_wr_en`=0, `req_ready`=0, and state and counters hold.
- **Non-granted requesters** see `req_ready`=0 regardless of FIFO state.
- **Combinational outputs:**
  - `fifo_wr_en` and `req_ready` are 0 whenever the state is IDLE.
  - `fifo_data` is zero in IDLE and otherwise shows slice g.
  - `busy` = (state == LOCK).
- **Widths:** `beat_cnt` is BW bits and never exceeds MAX_BURST-1 when stored. `rr_ptr` wraps from NREQ-1 to 0 by explicit compare, so NREQ need not be a power of two.
- **Reset (`rst_n` low, asynchronous):**
  - State goes to IDLE; `rr_ptr`, `grant_id` and `beat_cnt` go to 0.
  - `busy`, `fifo_wr_en` and `req_ready` become 0 immediately, without waiting for a clock edge.
  - A burst interrupted by reset is abandoned and no partial state is retained.
  - Registers leave reset on the first `CLK` edge after `rst_n` rises.

## Timing
- Arbitration latency: `req_valid` sampled high in IDLE at edge N gives LOCK from N; the first beat can be accepted in the cycle after edge N.
- There is one idle bubble cycle between consecutive bursts.
- Throughput within a burst is 1 beat per cycle while `!fifo_full`.
- `fifo_full` to `fifo_wr_en` is a purely combinational path with zero cycles of latency. This matches `sync_fifo`, which samples `wr_en && !full` on the same edge.
- Registered state updates only on accepted beats or IDLE arbitration.
- Single-beat burst (`req_last` on the first beat): LOCK lasts exactly one accept cycle.

## Test plan
1. **Single requester.** Reset, then requester 2 presents 3 beats (0xA1, 0xA2, 0xA3; last on the third), FIFO never full. Required: `grant_id`=2, `busy` high for 3 cycles, FIFO receives A1, A2, A3 on consecutive cycles, then `rr_ptr`=3.
2. **All requesters contending.** All four requesters hold valid with single-beat bursts (last=1). Required: grants are issued in order 0,1,2,3,0, with one bubble cycle between successive beats.
3. **MAX_BURST cap.** With MAX_BURST=4, requester 1 sends 6 beats with last never asserted while requester 0 is also valid. Required: 4 beats are written from requester 1, then requester 0 is granted, then requester 1 is granted again to send its remaining 2 beats.
4. **FIFO full mid-burst.** `fifo_full` is forced high for 3 cycles during the second beat. Required: `fifo_wr_en`=0 and `req_ready`=0 while full; beat 2 is written on the first non-full cycle; no beat is lost or duplicated; `beat_cnt` is unchanged during the stall.
5. **Reset mid-burst.** `rst_n` is pulsed low between clock edges during a burst. Required: `busy`, `fifo_wr_en` and `req_ready` drop to 0 before the next edge; after release, `grant_id`=0 and arbitration restarts from requester 0.
6. **Non-power-of-two wrap.** With NREQ=3, requester 2 completes a burst. Required: `rr_ptr` wraps to 0, and the next grant goes to requester 0 when all three requesters are valid.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NREQ valid/ready producers.
// Grants lock for up to MAX_BURST beats; the full flag gates writes combinationally.
module fifo_wr_arbiter #(
    parameter  int WIDTH     = 256,
    parameter  int NREQ      = 4,
    parameter  int MAX_BURST = 4,
    localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_last,
    input  logic [NREQ*8*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [8*WIDTH-1:0]      fifo_data,
    output logic [IW-1:0]           grant_id,
    output logic                    busy
);

    localparam int DW = 8 * WIDTH;

    // state | meaning
    // IDLE  | no grant held; arbitrate among valid requesters, no transfers
    // LOCK  | grant held by grant_q until its burst ends
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   scan_idx;
    logic            g_valid;
    logic            g_last;
    logic [DW-1:0]   g_data;
    logic            accept;
    logic            burst_end;

    // Upward scan from rr_ptr; explicit wrap keeps non-power-of-two NREQ in range.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
            if (scan_idx == IW'(NREQ - 1)) begin
                scan_idx = '0;
            end else begin
                scan_idx = IW'(scan_idx + 1'b1);
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == IW'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*DW +: DW];
            end
        end
    end

    assign accept    = (state_q == ST_LOCK) && g_valid && !fifo_full;
    assign burst_end = accept && (g_last || (int'(beat_cnt_q) + 1 == MAX_BURST));

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_LOCK;
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            ST_LOCK: begin
                if (accept) begin
                    beat_cnt_d = BW'(beat_cnt_q + 1'b1);
                    if (burst_end) begin
                        // Counter cleared so the stored value stays below MAX_BURST.
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                        rr_ptr_d   = (grant_q == IW'(NREQ - 1)) ? '0 : IW'(grant_q + 1'b1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (grant_q == IW'(i));
        end
    end

    assign fifo_wr_en = accept;
    assign fifo_data  = (state_q == ST_LOCK) ? g_data : '0;
    assign grant_id   = grant_q;
    assign busy       = (state_q == ST_LOCK);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter; two instances (NREQ=4 and NREQ=3)
// are compared every cycle against a queue-based producer/arbitration model.
module tb_fifo_wr_arbiter;

    localparam int DW = 32;
    localparam int MB = 4;

    logic CLK = 1'b0;
    logic rst_n;
    always #5 CLK = ~CLK;

    logic [3:0]   v0, l0, r0;
    logic [127:0] d0;
    logic         f0, w0, b0;
    logic [31:0]  fd0;
    logic [1:0]   g0;

    logic [2:0]   v1, l1, r1;
    logic [95:0]  d1;
    logic         f1, w1, b1;
    logic [31:0]  fd1;
    logic [1:0]   g1;

    fifo_wr_arbiter #(.WIDTH(4), .NREQ(4), .MAX_BURST(MB)) dut0 (
        .CLK(CLK), .rst_n(rst_n), .req_valid(v0), .req_last(l0), .req_data(d0),
        .req_ready(r0), .fifo_full(f0), .fifo_wr_en(w0), .fifo_data(fd0),
        .grant_id(g0), .busy(b0)
    );

    fifo_wr_arbiter #(.WIDTH(4), .NREQ(3), .MAX_BURST(MB)) dut1 (
        .CLK(CLK), .rst_n(rst_n), .req_valid(v1), .req_last(l1), .req_data(d1),
        .req_ready(r1), .fifo_full(f1), .fifo_wr_en(w1), .fifo_data(fd1),
        .grant_id(g1), .busy(b1)
    );

    // Producer queues, index u*4+i; bit 32 marks the last beat of a burst.
    logic [32:0] bq [8][$];
    int          m_lock [2];
    int          m_g    [2];
    int          m_cnt  [2];
    int          m_ptr  [2];
    logic        cur_v  [2][4];
    logic        cur_l  [2][4];
    logic [31:0] cur_d  [2][4];
    logic        cur_f  [2];
    bit          force_full [2];
    int          pv, pf, cyc, log_u;
    int          log_g [$];
    logic [31:0] log_d [$];
    int          log_c [$];
    int          exp_g [$];
    int          n_cmp, n_err;

    function automatic int nr(input int u);
        return (u == 0) ? 4 : 3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 4; i++) begin
                if (i < nr(u) && bq[u*4+i].size() > 0) begin
                    cur_v[u][i] = ($urandom_range(0, 99) < pv);
                    cur_l[u][i] = bq[u*4+i][0][32];
                    cur_d[u][i] = bq[u*4+i][0][31:0];
                end else begin
                    cur_v[u][i] = 1'b0;
                    cur_l[u][i] = 1'b0;
                    cur_d[u][i] = $urandom;
                end
            end
            cur_f[u] = force_full[u] || ($urandom_range(0, 99) < pf);
        end
        for (int i = 0; i < 4; i++) begin
            v0[i] = cur_v[0][i];
            l0[i] = cur_l[0][i];
            d0[i*32 +: 32] = cur_d[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            v1[i] = cur_v[1][i];
            l1[i] = cur_l[1][i];
            d1[i*32 +: 32] = cur_d[1][i];
        end
        f0 = cur_f[0];
        f1 = cur_f[1];
    endtask

    task automatic get_obs(input int u, output logic ob, output logic ow,
                           output logic [3:0] orr, output logic [31:0] od, output logic [1:0] og);
        if (u == 0) begin
            ob = b0; ow = w0; orr = r0; od = fd0; og = g0;
        end else begin
            ob = b1; ow = w1; orr = {1'b0, r1}; od = fd1; og = g1;
        end
    endtask

    task automatic check_outs();
        logic ob, ow;
        logic [3:0]  orr;
        logic [31:0] od;
        logic [1:0]  og;
        for (int u = 0; u < 2; u++) begin
            int   g;
            logic acc;
            logic [3:0]  e_rdy;
            logic [31:0] e_dat;
            g     = m_g[u];
            acc   = (m_lock[u] != 0) && cur_v[u][g] && !cur_f[u];
            e_rdy = acc ? 4'(1 << g) : 4'd0;
            e_dat = (m_lock[u] != 0) ? cur_d[u][g] : 32'd0;
            get_obs(u, ob, ow, orr, od, og);
            chk($sformatf("busy%0d", u), ob, m_lock[u]);
            chk($sformatf("wr_en%0d", u), ow, acc);
            chk($sformatf("ready%0d", u), orr, e_rdy);
            chk($sformatf("data%0d", u), od, e_dat);
            chk($sformatf("grant%0d", u), og, g);
            if (u == log_u && ow) begin
                log_g.push_back(int'(og));
                log_d.push_back(od);
                log_c.push_back(cyc);
            end
        end
    endtask

    task automatic check_reset_zero();
        logic ob, ow;
        logic [3:0]  orr;
        logic [31:0] od;
        logic [1:0]  og;
        for (int u = 0; u < 2; u++) begin
            get_obs(u, ob, ow, orr, od, og);
            chk($sformatf("rst_busy%0d", u), ob, 0);
            chk($sformatf("rst_wr%0d", u), ow, 0);
            chk($sformatf("rst_ready%0d", u), orr, 0);
            chk($sformatf("rst_grant%0d", u), og, 0);
            chk($sformatf("rst_data%0d", u), od, 0);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_lock[u] = 0; m_g[u] = 0; m_cnt[u] = 0; m_ptr[u] = 0;
        end
    endtask

    task automatic model_edge();
        for (int u = 0; u < 2; u++) begin
            int n;
            int g;
            n = nr(u);
            g = m_g[u];
            if (m_lock[u] == 0) begin
                for (int k = 0; k < n; k++) begin
                    int i;
                    i = (m_ptr[u] + k) % n;
                    if (m_lock[u] == 0 && cur_v[u][i]) begin
                        m_lock[u] = 1;
                        m_g[u]    = i;
                        m_cnt[u]  = 0;
                    end
                end
            end else if (cur_v[u][g] && !cur_f[u]) begin
                void'(bq[u*4+g].pop_front());
                m_cnt[u]++;
                if (cur_l[u][g] || m_cnt[u] == MB) begin
                    m_lock[u] = 0;
                    m_ptr[u]  = (g + 1) % n;
                end
            end
        end
    endtask

    task automatic step(input bit do_rst);
        drive();
        #1;
        check_outs();
        if (do_rst) begin
            rst_n = 1'b0;
            #1;
            check_reset_zero();
            model_reset();
            #1;
            rst_n = 1'b1;
        end
        @(posedge CLK);
        model_edge();
        cyc++;
        @(negedge CLK);
    endtask

    function automatic bit pending();
        bit p;
        p = (m_lock[0] != 0) || (m_lock[1] != 0);
        for (int j = 0; j < 8; j++) begin
            if (bq[j].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drain(input int maxc);
        int k;
        k = 0;
        while (pending() && k < maxc) begin
            step(1'b0);
            k++;
        end
        chk("drain_left", pending(), 0);
    endtask

    task automatic clear_log();
        log_g.delete();
        log_d.delete();
        log_c.delete();
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, log_g.size(), exp_g.size());
        for (int i = 0; i < exp_g.size(); i++) begin
            if (i < log_g.size()) chk($sformatf("%s[%0d]", tag, i), log_g[i], exp_g[i]);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; log_u = 0;
        pv = 100; pf = 0;
        force_full[0] = 1'b0; force_full[1] = 1'b0;
        model_reset();
        rst_n = 1'b0;
        drive();
        repeat (2) @(negedge CLK);
        check_reset_zero();
        rst_n = 1'b1;

        // Single requester, then rotation continues after requester 2.
        clear_log();
        bq[2].push_back({1'b0, 32'hA1});
        bq[2].push_back({1'b0, 32'hA2});
        bq[2].push_back({1'b1, 32'hA3});
        step(1'b0);
        bq[3].push_back({1'b1, 32'hD3});
        bq[0].push_back({1'b1, 32'hD0});
        drain(60);
        exp_g = '{2, 2, 2, 3, 0};
        chk_log("t1_grant");
        if (log_d.size() >= 3) begin
            chk("t1_d0", log_d[0], 32'hA1);
            chk("t1_d1", log_d[1], 32'hA2);
            chk("t1_d2", log_d[2], 32'hA3);
            chk("t1_consec", log_c[2] - log_c[0], 2);
        end

        // All four contending with single-beat bursts.
        step(1'b1);
        clear_log();
        bq[0].push_back({1'b1, 32'hE0});
        bq[0].push_back({1'b1, 32'hE4});
        bq[1].push_back({1'b1, 32'hE1});
        bq[2].push_back({1'b1, 32'hE2});
        bq[3].push_back({1'b1, 32'hE3});
        drain(60);
        exp_g = '{0, 1, 2, 3, 0};
        chk_log("t2_grant");
        for (int i = 1; i < log_c.size(); i++) chk("t2_bubble", log_c[i] - log_c[i-1], 2);

        // Burst cap: requester 1 sends 6 beats without last.
        step(1'b1);
        clear_log();
        for (int k = 0; k < 6; k++) bq[1].push_back({1'b0, 32'(32'h10 + k)});
        step(1'b0);
        bq[0].push_back({1'b0, 32'hF0});
        bq[0].push_back({1'b1, 32'hF1});
        repeat (14) step(1'b0);
        exp_g = '{1, 1, 1, 1, 0, 0, 1, 1};
        chk_log("t3_grant");

        // Reset while requester 1 is still mid-burst and writing.
        bq[1].push_back({1'b0, 32'hB0});
        bq[1].push_back({1'b0, 32'hB1});
        step(1'b0);
        drive();
        #1;
        check_outs();
        chk("t5_wr_before", w0, 1);
        rst_n = 1'b0;
        #1;
        check_reset_zero();
        model_reset();
        bq[1].delete();
        bq[0].push_back({1'b1, 32'hC0});
        bq[3].push_back({1'b1, 32'hC3});
        drive();
        #1;
        rst_n = 1'b1;
        @(posedge CLK);
        model_edge();
        cyc++;
        @(negedge CLK);
        clear_log();
        drain(60);
        exp_g = '{0, 3};
        chk_log("t5_grant");

        // FIFO full for 3 cycles during the second beat.
        step(1'b1);
        clear_log();
        bq[2].push_back({1'b0, 32'hB1});
        bq[2].push_back({1'b0, 32'hB2});
        bq[2].push_back({1'b1, 32'hB3});
        step(1'b0);
        step(1'b0);
        force_full[0] = 1'b1;
        repeat (3) step(1'b0);
        force_full[0] = 1'b0;
        drain(60);
        chk("t4_len", log_d.size(), 3);
        if (log_d.size() >= 3) begin
            chk("t4_d0", log_d[0], 32'hB1);
            chk("t4_d1", log_d[1], 32'hB2);
            chk("t4_d2", log_d[2], 32'hB3);
            chk("t4_stall", log_c[1] - log_c[0], 4);
        end

        // NREQ=3 wrap after requester 2.
        log_u = 1;
        step(1'b1);
        clear_log();
        bq[6].push_back({1'b1, 32'h92});
        step(1'b0);
        bq[4].push_back({1'b1, 32'h90});
        bq[5].push_back({1'b1, 32'h91});
        bq[6].push_back({1'b1, 32'h93});
        drain(60);
        exp_g = '{2, 0, 1, 2};
        chk_log("t6_grant");

        // Random traffic with stalls, drops and occasional resets.
        log_u = -1;
        pv = 75; pf = 25;
        for (int s = 0; s < 3000; s++) begin
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < nr(u); i++) begin
                    if (bq[u*4+i].size() == 0 && $urandom_range(0, 99) < 20) begin
                        int len;
                        len = $urandom_range(1, 6);
                        for (int k = 0; k < len; k++)
                            bq[u*4+i].push_back({(k == len - 1), 32'($urandom)});
                    end
                end
            end
            step($urandom_range(0, 499) == 0);
        end
        pv = 100; pf = 0;
        drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
